// File: rtl/calc_pkg.sv
// calc_pkg: shared types and defaults for the calculator keypad-entry block.
//   key_type_e : decoded key class (DIGIT/OP/ENTER/CLEAR)
//   op_e       : operator code latched with operand A
//   disp_sel_e : display source select (ENTRY/RESULT/ERROR)
//   state_e    : entry sequencer states
package calc_pkg;

    localparam int unsigned DIGITS_DEFAULT = 3;

    typedef enum logic [1:0] {
        KeyDigit = 2'd0,
        KeyOp    = 2'd1,
        KeyEnter = 2'd2,
        KeyClear = 2'd3
    } key_type_e;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2,
        OpDiv = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        DispEntry  = 2'd0,
        DispResult = 2'd1,
        DispError  = 2'd2
    } disp_sel_e;

    typedef enum logic [2:0] {
        StEntryA = 3'd0,
        StEntryB = 3'd1,
        StStart  = 3'd2,
        StWait   = 3'd3,
        StShow   = 3'd4
    } state_e;

endpackage

// File: rtl/calc_entry_ctrl_wait_timer.sv
// wait_timer: down-counter bounding a wait to COUNT enabled cycles.
//   clk, rst : clock and synchronous active-high reset
//   load     : preload to COUNT-1 (first enabled cycle of the wait follows)
//   en       : count down one per cycle while high
//   expire   : high in the COUNT-th enabled cycle after a load
module wait_timer #(
    parameter int unsigned COUNT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(COUNT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expire = en && !load && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-entry sequencer for the calculator.
//   Inputs : clk, rst (sync, active-high), key_valid/key_type/key_val (decoded key),
//            bcd_value (digit register contents), alu_done (ALU completion pulse)
//   Outputs: digit_valid/digit_val/digit_clear (Mealy, drive the digit register),
//            operand_a/operand_b/op_code (latched), alu_start (pulse), busy,
//            disp_sel (ENTRY/RESULT/ERROR), error (sticky timeout flag)
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS  = DIGITS_DEFAULT,
    parameter int unsigned W       = 4 * DIGITS,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [1:0]   key_type,
    input  logic [3:0]   key_val,
    input  logic [W-1:0] bcd_value,
    output logic         digit_valid,
    output logic [3:0]   digit_val,
    output logic         digit_clear,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   op_code,
    output logic         alu_start,
    input  logic         alu_done,
    output logic         busy,
    output logic [1:0]   disp_sel,
    output logic         error
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);

    state_e      state_q, state_d;
    logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
    op_e         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  pend_val_q, pend_val_d;
    logic        err_q, err_d;
    disp_sel_e   disp_q, disp_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        timer_load, timer_en, timer_expire;

    logic is_digit, is_op, is_enter, is_clear, room;

    assign is_digit = key_valid && (key_type == KeyDigit);
    assign is_op    = key_valid && (key_type == KeyOp);
    assign is_enter = key_valid && (key_type == KeyEnter);
    assign is_clear = key_valid && (key_type == KeyClear);
    assign room     = (cnt_q < CNT_W'(DIGITS));

    wait_timer #(
        .COUNT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        err_d       = err_q;
        disp_d      = disp_q;
        digit_valid = 1'b0;
        digit_val   = key_val;
        digit_clear = 1'b0;
        timer_load  = 1'b0;
        timer_en    = 1'b0;

        unique case (state_q)
            StEntryA: begin
                if (is_digit && room) begin
                    digit_valid = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end else if (is_op) begin
                    opa_d       = bcd_value;
                    op_d        = op_e'(key_val[1:0]);
                    digit_clear = 1'b1;
                    cnt_d       = '0;
                    state_d     = StEntryB;
                end
            end
            StEntryB: begin
                if (is_digit && room) begin
                    digit_valid = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end else if (is_op) begin
                    op_d = op_e'(key_val[1:0]);
                end else if (is_enter && (cnt_q != '0)) begin
                    opb_d       = bcd_value;
                    digit_clear = 1'b1;
                    cnt_d       = '0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                timer_load = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                timer_en = 1'b1;
                if (alu_done) begin
                    disp_d  = DispResult;
                    state_d = StShow;
                end else if (timer_expire) begin
                    err_d   = 1'b1;
                    disp_d  = DispError;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (pend_q) begin
                    // Register was cleared last cycle; shift in the held digit as the
                    // first digit of a new operand A. Any key this cycle is dropped.
                    digit_valid = 1'b1;
                    digit_val   = pend_val_q;
                    pend_d      = 1'b0;
                    cnt_d       = CNT_W'(1);
                    err_d       = 1'b0;
                    disp_d      = DispEntry;
                    state_d     = StEntryA;
                end else if (is_digit) begin
                    digit_clear = 1'b1;
                    pend_d      = 1'b1;
                    pend_val_d  = key_val;
                end
            end
            default: state_d = StEntryA;
        endcase

        // CLEAR overrides everything, including a coincident alu_done in WAIT.
        if (is_clear) begin
            digit_valid = 1'b0;
            digit_clear = 1'b1;
            opa_d       = '0;
            opb_d       = '0;
            cnt_d       = '0;
            pend_d      = 1'b0;
            err_d       = 1'b0;
            disp_d      = DispEntry;
            state_d     = StEntryA;
        end

        start_d = (state_d == StStart);
        busy_d  = (state_d == StStart) || (state_d == StWait);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEntryA;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= OpAdd;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            err_q      <= 1'b0;
            disp_q     <= DispEntry;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            err_q      <= err_d;
            disp_q     <= disp_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign operand_a = opa_q;
    assign operand_b = opb_q;
    assign op_code   = op_q;
    assign alu_start = start_q;
    assign busy      = busy_q;
    assign disp_sel  = disp_q;
    assign error     = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed self-checking bench for calc_entry_ctrl.
// Models the 12-bit BCD digit register around the DUT; expected shifted digits
// are queued when keys are driven and compared whenever digit_valid fires.
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    localparam int unsigned DIGITS  = 3;
    localparam int unsigned W       = 12;
    localparam int unsigned TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [1:0]   key_type;
    logic [3:0]   key_val;
    logic [W-1:0] bcd = '0;
    logic         digit_valid;
    logic [3:0]   digit_val;
    logic         digit_clear;
    logic [W-1:0] operand_a, operand_b;
    logic [1:0]   op_code;
    logic         alu_start;
    logic         alu_done;
    logic         busy;
    logic [1:0]   disp_sel;
    logic         error;

    int compared   = 0;
    int mismatched = 0;
    int n_dv       = 0;
    int n_dc       = 0;
    int n_start    = 0;
    int base;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    calc_entry_ctrl #(
        .DIGITS  (DIGITS),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_type    (key_type),
        .key_val     (key_val),
        .bcd_value   (bcd),
        .digit_valid (digit_valid),
        .digit_val   (digit_val),
        .digit_clear (digit_clear),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .busy        (busy),
        .disp_sel    (disp_sel),
        .error       (error)
    );

    // Digit shift register as it sits next to the DUT; clear has priority.
    always @(posedge clk) begin
        if (digit_clear) bcd <= '0;
        else if (digit_valid) bcd <= {bcd[W-5:0], digit_val};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every digit_valid must match the oldest queued digit.
    always @(negedge clk) begin
        if (digit_valid) begin
            n_dv++;
            if (exp_q.size() == 0) check("dv_unexpected", 32'(digit_valid), 32'(0));
            else check("digit_val", 32'(digit_val), 32'(exp_q.pop_front()));
        end
        if (digit_clear) n_dc++;
        if (alu_start) n_start++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key_cycle(input key_type_e t, input logic [3:0] v);
        key_valid = 1'b1;
        key_type  = t;
        key_val   = v;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic digit(input logic [3:0] v, input bit accept);
        if (accept) exp_q.push_back(v);
        key_cycle(KeyDigit, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_type = 2'd0; key_val = 4'd0; alu_done = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_opa", 32'(operand_a), 32'h0);
        check("rst_opb", 32'(operand_b), 32'h0);
        check("rst_op", 32'(op_code), 32'h0);
        check("rst_start", 32'(alu_start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_disp", 32'(disp_sel), 32'(DispEntry));
        check("rst_err", 32'(error), 32'h0);
        base = n_dv + n_dc + n_start;
        idle(10);
        check("idle_pulses", 32'(n_dv + n_dc + n_start - base), 32'h0);

        // Full calculation 123 op0 45
        base = n_start;
        digit(4'd1, 1); digit(4'd2, 1); digit(4'd3, 1);
        key_cycle(KeyOp, 4'd0);
        check("opa_123", 32'(operand_a), 32'h123);
        check("op_0", 32'(op_code), 32'h0);
        digit(4'd4, 1); digit(4'd5, 1);
        key_cycle(KeyEnter, 4'd0);
        check("start_n1", 32'(alu_start), 32'h1);
        check("opb_045", 32'(operand_b), 32'h045);
        idle(1);
        check("start_n2", 32'(alu_start), 32'h0);
        check("busy_wait", 32'(busy), 32'h1);
        idle(3);
        alu_done = 1'b1;
        idle(1);
        alu_done = 1'b0;
        check("disp_result", 32'(disp_sel), 32'(DispResult));
        check("busy_done", 32'(busy), 32'h0);
        check("start_count", 32'(n_start - base), 32'h1);

        // Digit overflow, ENTER ignored in ENTRY_A, ENTRY_B corner cases
        key_cycle(KeyClear, 4'd0);
        check("clr_disp", 32'(disp_sel), 32'(DispEntry));
        digit(4'd1, 1); digit(4'd2, 1); digit(4'd3, 1); digit(4'd4, 0);
        check("bcd_123", 32'(bcd), 32'h123);
        key_cycle(KeyEnter, 4'd0);
        check("enter_a_ign", 32'(busy), 32'h0);
        key_cycle(KeyOp, 4'd2);
        check("opa_123b", 32'(operand_a), 32'h123);
        check("op_2", 32'(op_code), 32'h2);
        key_cycle(KeyEnter, 4'd0);
        check("enter_b0_ign", 32'(busy), 32'h0);
        key_cycle(KeyOp, 4'd1);
        check("op_1", 32'(op_code), 32'h1);
        check("opa_keep", 32'(operand_a), 32'h123);
        digit(4'd9, 1);
        key_cycle(KeyEnter, 4'd0);
        check("opb_b2b", 32'(operand_b), 32'h009);
        check("start_b2b", 32'(alu_start), 32'h1);

        // Timeout: TIMEOUT cycles in WAIT, error on the following edge
        idle(TIMEOUT);
        check("err_pre", 32'(error), 32'h0);
        check("busy_pre", 32'(busy), 32'h1);
        idle(1);
        check("err_set", 32'(error), 32'h1);
        check("disp_err", 32'(disp_sel), 32'(DispError));
        check("busy_to", 32'(busy), 32'h0);
        alu_done = 1'b1;
        idle(1);
        alu_done = 1'b0;
        idle(1);
        check("late_disp", 32'(disp_sel), 32'(DispError));
        check("late_err", 32'(error), 32'h1);

        // DIGIT in SHOW: clear at n, pending digit at n+1; key in pending cycle dropped
        exp_q.push_back(4'd7);
        key_valid = 1'b1; key_type = KeyDigit; key_val = 4'd7;
        @(negedge clk);
        check("show_clr", 32'(digit_clear), 32'h1);
        check("show_nodv", 32'(digit_valid), 32'h0);
        @(posedge clk);
        #1;
        key_val = 4'd8;
        @(negedge clk);
        check("pend_dv", 32'(digit_valid), 32'h1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("pend_disp", 32'(disp_sel), 32'(DispEntry));
        check("pend_err", 32'(error), 32'h0);
        check("bcd_007", 32'(bcd), 32'h007);

        // CLEAR coincident with alu_done in WAIT
        key_cycle(KeyOp, 4'd3);
        check("opa_007", 32'(operand_a), 32'h007);
        check("op_3", 32'(op_code), 32'h3);
        digit(4'd2, 1);
        key_cycle(KeyEnter, 4'd0);
        idle(2);
        check("wait_busy", 32'(busy), 32'h1);
        alu_done = 1'b1;
        key_cycle(KeyClear, 4'd0);
        alu_done = 1'b0;
        check("cw_disp", 32'(disp_sel), 32'(DispEntry));
        check("cw_busy", 32'(busy), 32'h0);
        check("cw_opa", 32'(operand_a), 32'h0);
        check("cw_opb", 32'(operand_b), 32'h0);
        idle(2);
        check("cw_disp2", 32'(disp_sel), 32'(DispEntry));

        // Reset mid-sequence overrides a key and clears the digit count
        digit(4'd5, 1);
        rst = 1'b1;
        key_cycle(KeyOp, 4'd2);
        rst = 1'b0;
        check("rst_mid_opa", 32'(operand_a), 32'h0);
        check("rst_mid_op", 32'(op_code), 32'h0);
        digit(4'd1, 1); digit(4'd2, 1); digit(4'd3, 1);
        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-entry sequencer for the Lab 4 calculator. It sits between the scan-code decoder and the 12-bit BCD digit shift register, and drives that register's `valid_scan_code` and `op_ctrl` inputs. It captures operand A, the operator and operand B from the register, starts the ALU, waits for completion with a timeout, and selects what the display shows.

## Interface
- `DIGITS`, default 3: maximum BCD digits per operand.
- `W`, default 4*DIGITS: operand width.
- `TIMEOUT`, default 1024: maximum cycles to wait for `alu_done`.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `key_valid`  in  1  one-cycle pulse marking a decoded key.
- `key_type`  in  2  DIGIT=0, OP=1, ENTER=2, CLEAR=3.
- `key_val`  in  4  digit value 0–9 (DIGIT) or operator code in bits [1:0] (OP).
- `bcd_value`  in  W  current contents of the digit register.
- `digit_valid`  out  1  to the register's `valid_scan_code`; shifts in `digit_val`.
- `digit_val`  out  4  digit to shift in.
- `digit_clear`  out  1  to the register's `op_ctrl`; clears it. Has priority in the register.
- `operand_a`, `operand_b`  out  W  latched operands.
- `op_code`  out  2  latched operator.
- `alu_start`  out  1  one-cycle pulse.
- `alu_done`  in  1  ALU completion pulse.
- `busy`  out  1  high in START and WAIT.
- `disp_sel`  out  2  ENTRY=0, RESULT=1, ERROR=2.
- `error`  out  1  sticky timeout flag.

## Operation
- FSM states: ENTRY_A, ENTRY_B, START, WAIT, SHOW.
- Reset sets state ENTRY_A, operands 0, `op_code` 0, digit count 0, pending flag 0, `error` 0 and `disp_sel` ENTRY. All pulse outputs are 0.
- `digit_valid`, `digit_val` and `digit_clear` are combinational functions of the key inputs and the current state (Mealy outputs). All other outputs are registered.
- A DIGIT key in ENTRY_A or ENTRY_B:
  - If digit count < DIGITS: assert `digit_valid` the same cycle with `digit_val` = `key_val`, and increment the count.
  - Otherwise ignore the key.
- ENTRY_A:
  - OP: set `operand_a` ← `bcd_value` and `op_code` ← `key_val[1:0]`. Pulse `digit_clear`, reset the count and go to ENTRY_B.
  - ENTER: ignored.
- ENTRY_B:
  - OP: replace `op_code` only.
  - ENTER with count 0: ignored.
  - ENTER with count > 0: set `operand_b` ← `bcd_value`, pulse `digit_clear` and go to START.
- START: assert `alu_start` for one cycle, clear the timer and go to WAIT.
- WAIT: all keys except CLEAR are ignored.
  - `alu_done`: go to SHOW with `disp_sel` RESULT.
  - Timer reaches TIMEOUT-1 with no `alu_done`: set `error`=1, `disp_sel` ERROR and go to SHOW.
- SHOW:
  - DIGIT: pulse `digit_clear` this cycle and store the digit as pending. Next cycle, assert `digit_valid` with the pending digit, set count 1, `error` 0, `disp_sel` ENTRY and go to ENTRY_A.
  - Any key arriving in the pending cycle is dropped.
  - OP and ENTER: ignored.
- CLEAR in any state: pulse `digit_clear`, zero both operands, count, pending flag and `error`, set `disp_sel` ENTRY and go to ENTRY_A.
- `alu_done` outside WAIT is ignored. This covers a late done after a timeout or a CLEAR.

## Timing
- Digit key at cycle n: the register updates at the end of n, and `bcd_value` is valid at n+1. A back-to-back OP or ENTER at n+1 must capture the updated value.
- ENTER at n: `alu_start` is high in n+1, and WAIT is entered at n+2.
- `alu_done` at cycle m in WAIT: `disp_sel` becomes RESULT at m+1.
- Timeout: exactly TIMEOUT cycles in WAIT without done; `error` rises on the following edge.
- Simultaneous `key_valid`=CLEAR and `alu_done` in WAIT: CLEAR wins and the result is discarded.
- `rst` mid-sequence returns to the reset state on the next edge, overriding all keys.

## Structure
- Shared package `calc_pkg` holds:
  - `key_type_e`, `op_e`, `disp_sel_e`, `state_e`;
  - the `DIGITS` default.
- Sub-module `wait_timer` is a parameterised down-counter with load, enable and expire outputs; it is instantiated once for the WAIT timeout.

## Test plan
- Reset: all outputs zero, `disp_sel`=ENTRY; `key_valid`=0 for 10 cycles → no pulses.
- Keys 1,2,3, OP(0), 4,5, ENTER, then `alu_done` 5 cycles after start → three then two `digit_valid` pulses, `operand_a`=0x123, `operand_b`=0x045, one `alu_start`, `disp_sel`=RESULT.
- Keys 1,2,3,4 → only three `digit_valid` pulses and `bcd_value`=0x123. ENTER in ENTRY_A is ignored.
- In ENTRY_B: ENTER with no digits is ignored; OP(2) then OP(1) leaves `op_code`=1; back-to-back digit-then-ENTER captures the new `bcd_value`.
- No `alu_done` for TIMEOUT cycles → `error`=1 and `disp_sel`=ERROR; a late `alu_done` causes no change.
- CLEAR during WAIT → ENTRY_A with operands 0. DIGIT 7 in SHOW → `digit_clear` at n, `digit_valid` with `digit_val`=7 at n+1, `disp_sel`=ENTRY.
